// File: rtl/pc_control_if.sv
// rtl/pc_control_if.sv - branch/jump control bundle between decode/execute and the PC controller
//
// Purpose: groups every non-clock, non-reset signal of pc_control so the
// datapath and the controller connect through one port.
//
// Port summary (directions seen from the slave, i.e. pc_control):
//   BrEq, BrLt      in   branch comparator results
//   Funct3          in   branch funct3 of the current instruction
//   Branch/Jal/Jalr in   instruction class flags
//   InstValid       in   current instruction is valid
//   Stall           in   hold PC and state this cycle
//   Target          in   ALU-computed redirect address
//   BrUn            out  unsigned-compare select to the comparator
//   PC              out  registered fetch address
//   PCSel           out  redirect accepted this cycle (combinational)
//   Flush           out  kill the wrong-path instruction
//   Misalign        out  sticky misaligned-target trap flag
//   TakenCount      out  count of accepted redirects
interface pc_control_if #(
  parameter int DWIDTH = 32
);
  logic              BrEq;
  logic              BrLt;
  logic [2:0]        Funct3;
  logic              Branch;
  logic              Jal;
  logic              Jalr;
  logic              InstValid;
  logic              Stall;
  logic [DWIDTH-1:0] Target;
  logic              BrUn;
  logic [DWIDTH-1:0] PC;
  logic              PCSel;
  logic              Flush;
  logic              Misalign;
  logic [15:0]       TakenCount;

  // Datapath side: drives instruction/comparator info, observes PC control.
  modport master (
    output BrEq, BrLt, Funct3, Branch, Jal, Jalr, InstValid, Stall, Target,
    input  BrUn, PC, PCSel, Flush, Misalign, TakenCount
  );

  // Controller side.
  modport slave (
    input  BrEq, BrLt, Funct3, Branch, Jal, Jalr, InstValid, Stall, Target,
    output BrUn, PC, PCSel, Flush, Misalign, TakenCount
  );
endinterface

// File: rtl/pc_control.sv
// rtl/pc_control.sv - program counter and branch/jump redirect controller
//
// Purpose: owns the fetch PC. Resolves conditional branches from comparator
// results, applies JAL/JALR redirects, raises Flush for the one wrong-path
// instruction after a taken redirect, and traps into HALT on a misaligned
// redirect target.
//
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  synchronous active-high reset
//   bus   pc_control_if.slave (see interface file for the signal list)
//
// Parameters:
//   DWIDTH      width of PC, Target and address paths
//   RESET_PC    PC value loaded on reset
//   COUNT_INIT  TakenCount value loaded on reset (normally zero)
module pc_control #(
  parameter int                DWIDTH     = 32,
  parameter logic [DWIDTH-1:0] RESET_PC   = '0,
  parameter logic [15:0]       COUNT_INIT = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  pc_control_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] pc_q;
  logic              flush_q;
  logic              misalign_q;
  logic [15:0]       count_q;

  logic              cond;
  logic              redirect;
  logic [DWIDTH-1:0] eff_target;
  logic              aligned;
  logic              accept;

  // Branch condition from funct3; 010/011 are not branch encodings.
  always_comb begin
    cond = 1'b0;
    case (bus.Funct3)
      3'b000:          cond = bus.BrEq;
      3'b001:          cond = ~bus.BrEq;
      3'b100, 3'b110:  cond = bus.BrLt;
      3'b101, 3'b111:  cond = ~bus.BrLt;
      default:         cond = 1'b0;
    endcase
  end

  // Jal has priority over Jalr, so bit 0 is only cleared when Jalr is the
  // winning request; a Jal with an odd target must still trap.
  always_comb begin
    eff_target = bus.Target;
    if (!bus.Jal && bus.Jalr) begin
      eff_target = {bus.Target[DWIDTH-1:1], 1'b0};
    end
  end

  assign redirect = bus.Jal | bus.Jalr | (bus.Branch & cond);
  assign aligned  = (eff_target[1:0] == 2'b00);
  assign accept   = (state == RUN) && bus.InstValid && !bus.Stall;

  assign bus.BrUn       = (bus.Funct3[2:1] == 2'b11);
  assign bus.PCSel      = !rst && accept && redirect && aligned;
  assign bus.PC         = pc_q;
  assign bus.Flush      = flush_q;
  assign bus.Misalign   = misalign_q;
  assign bus.TakenCount = count_q;

  // Flush is registered alongside the state so it equals (state == FLUSH)
  // without a decode path on the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= COUNT_INIT;
    end else begin
      case (state)
        RUN: begin
          if (!bus.Stall) begin
            if (bus.InstValid && redirect) begin
              if (aligned) begin
                pc_q    <= eff_target;
                count_q <= count_q + 16'd1;
                state   <= FLUSH;
                flush_q <= 1'b1;
              end else begin
                // PC and TakenCount freeze; only reset leaves HALT.
                misalign_q <= 1'b1;
                state      <= HALT;
              end
            end else begin
              // Invalid slots still advance fetch.
              pc_q <= pc_q + DWIDTH'(4);
            end
          end
        end
        FLUSH: begin
          if (!bus.Stall) begin
            pc_q    <= pc_q + DWIDTH'(4);
            state   <= RUN;
            flush_q <= 1'b0;
          end
        end
        HALT: begin
          flush_q <= 1'b0;
        end
        default: begin
          state   <= RUN;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// tb/tb_pc_control.sv - directed self-checking bench for pc_control
module tb_pc_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pc_control_if #(.DWIDTH(32)) b1 ();
  pc_control_if #(.DWIDTH(32)) b2 ();

  pc_control #(.DWIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  // Second instance reset close to the counter limit for the wrap test.
  pc_control #(.DWIDTH(32), .RESET_PC(32'h0000_0000), .COUNT_INIT(16'hFEFF)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    b1.BrEq = 0; b1.BrLt = 0; b1.Funct3 = 3'b000; b1.Branch = 0;
    b1.Jal = 0; b1.Jalr = 0; b1.InstValid = 0; b1.Stall = 0; b1.Target = '0;
  endtask

  initial begin
    idle1();
    b2.BrEq = 0; b2.BrLt = 0; b2.Funct3 = 3'b000; b2.Branch = 0;
    b2.Jal = 0; b2.Jalr = 0; b2.InstValid = 0; b2.Stall = 0; b2.Target = '0;

    // Reset state, and PCSel forced low while rst is high.
    rst = 1;
    step();
    b1.InstValid = 1; b1.Jal = 1; b1.Target = 32'h0;
    #1;
    chk("pcsel_in_reset", b1.PCSel, 0);
    chk("reset_pc", b1.PC, 32'h0);
    chk("reset_flush", b1.Flush, 0);
    chk("reset_misalign", b1.Misalign, 0);
    chk("reset_count", b1.TakenCount, 0);
    step();
    idle1();
    rst = 0;

    // Sequential fetch.
    b1.InstValid = 1;
    #1;
    chk("seq_pcsel", b1.PCSel, 0);
    step(); chk("seq_pc4", b1.PC, 32'h4);
    step(); chk("seq_pc8", b1.PC, 32'h8);
    step(); chk("seq_pcc", b1.PC, 32'hC);
    chk("seq_flush", b1.Flush, 0);
    step(); chk("seq_pc10", b1.PC, 32'h10);

    // BEQ taken at 0x10 -> 0x40.
    b1.Branch = 1; b1.Funct3 = 3'b000; b1.BrEq = 1; b1.Target = 32'h40;
    #1;
    chk("beq_pcsel", b1.PCSel, 1);
    step();
    chk("beq_pc", b1.PC, 32'h40);
    chk("beq_flush", b1.Flush, 1);
    chk("beq_count", b1.TakenCount, 1);
    // FLUSH ignores the still-asserted branch.
    chk("flush_pcsel", b1.PCSel, 0);
    step();
    chk("after_flush_pc", b1.PC, 32'h44);
    chk("after_flush_flush", b1.Flush, 0);
    chk("after_flush_count", b1.TakenCount, 1);

    // BrUn decode and not-taken conditions.
    b1.Funct3 = 3'b110; #1; chk("brun_110", b1.BrUn, 1);
    b1.Funct3 = 3'b111; #1; chk("brun_111", b1.BrUn, 1);
    b1.Funct3 = 3'b100; b1.BrLt = 0; b1.BrEq = 0; b1.Target = 32'h200;
    #1;
    chk("brun_100", b1.BrUn, 0);
    chk("blt_nt_pcsel", b1.PCSel, 0);
    step(); chk("blt_nt_pc", b1.PC, 32'h48);
    b1.Funct3 = 3'b010; b1.BrLt = 1; b1.BrEq = 1;
    #1; chk("f010_pcsel", b1.PCSel, 0);
    b1.Funct3 = 3'b001;
    #1; chk("bne_nt_pcsel", b1.PCSel, 0);
    b1.Funct3 = 3'b101; b1.BrLt = 0; b1.Target = 32'h300;
    #1; chk("bge_t_pcsel", b1.PCSel, 1);
    b1.Branch = 0;
    step(); chk("f001_pc", b1.PC, 32'h4C);

    // Stall in RUN holds everything.
    b1.Stall = 1; b1.Jal = 1; b1.Target = 32'h100;
    #1; chk("stall_pcsel", b1.PCSel, 0);
    step();
    chk("stall_pc", b1.PC, 32'h4C);
    chk("stall_count", b1.TakenCount, 1);

    // InstValid=0 ignores the jump but still advances.
    b1.Stall = 0; b1.InstValid = 0;
    #1; chk("inv_pcsel", b1.PCSel, 0);
    step(); chk("inv_pc", b1.PC, 32'h50);

    // JALR clears bit 0; then stall twice in FLUSH.
    b1.InstValid = 1; b1.Jal = 0; b1.Jalr = 1; b1.Target = 32'h81;
    #1; chk("jalr_pcsel", b1.PCSel, 1);
    step();
    chk("jalr_pc", b1.PC, 32'h80);
    chk("jalr_count", b1.TakenCount, 2);
    b1.Jalr = 0; b1.Stall = 1;
    step(); chk("fstall1_flush", b1.Flush, 1); chk("fstall1_pc", b1.PC, 32'h80);
    step(); chk("fstall2_flush", b1.Flush, 1); chk("fstall2_pc", b1.PC, 32'h80);
    b1.Stall = 0;
    step(); chk("fstall_exit_pc", b1.PC, 32'h84); chk("fstall_exit_flush", b1.Flush, 0);

    // Misaligned JAL -> HALT.
    b1.Jal = 1; b1.Target = 32'h82;
    #1; chk("jal_mis_pcsel", b1.PCSel, 0);
    step();
    chk("halt_pc", b1.PC, 32'h84);
    chk("halt_misalign", b1.Misalign, 1);
    chk("halt_count", b1.TakenCount, 2);
    chk("halt_flush", b1.Flush, 0);
    b1.Target = 32'h100;
    #1; chk("halt_pcsel", b1.PCSel, 0);
    step(); step();
    chk("halt_hold_pc", b1.PC, 32'h84);
    chk("halt_hold_count", b1.TakenCount, 2);

    // Reset out of HALT.
    rst = 1;
    step();
    idle1();
    rst = 0;
    chk("halt_rst_pc", b1.PC, 32'h0);
    chk("halt_rst_misalign", b1.Misalign, 0);
    chk("halt_rst_count", b1.TakenCount, 0);

    // Jal beats Jalr: odd target must trap instead of being realigned.
    b1.InstValid = 1; b1.Jal = 1; b1.Jalr = 1; b1.Target = 32'h81;
    #1; chk("prio_pcsel", b1.PCSel, 0);
    step();
    chk("prio_misalign", b1.Misalign, 1);
    chk("prio_pc", b1.PC, 32'h0);

    // Reset in the middle of FLUSH.
    rst = 1; step(); rst = 0;
    b1.Jal = 1; b1.Jalr = 0; b1.Target = 32'h20;
    step();
    chk("mid_flush_flush", b1.Flush, 1);
    rst = 1; step(); rst = 0;
    idle1();
    chk("mid_rst_pc", b1.PC, 32'h0);
    chk("mid_rst_flush", b1.Flush, 0);
    chk("mid_rst_count", b1.TakenCount, 0);

    // TakenCount wrap on the preloaded instance: 0xFEFF + 257 = 0x10000.
    chk("wrap_init", b2.TakenCount, 32'hFEFF);
    b2.InstValid = 1; b2.Jal = 1; b2.Target = 32'h100;
    for (int i = 0; i < 256; i++) begin
      step();
      step();
    end
    chk("wrap_ffff", b2.TakenCount, 32'hFFFF);
    chk("wrap_pre_pc", b2.PC, 32'h104);
    step();
    chk("wrap_zero", b2.TakenCount, 32'h0);
    chk("wrap_pc", b2.PC, 32'h100);
    chk("wrap_flush", b2.Flush, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
